// File: rtl/link_pkg.sv
// Shared types for the linked-list table engine: order opcodes, response
// error codes and controller states.
package link_pkg;

    typedef enum logic [2:0] {
        OP_APPE = 3'd0,
        OP_DELE = 3'd1,
        OP_CHAG = 3'd2,
        OP_READ = 3'd3,
        OP_LEN  = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        ERR_OK        = 3'd0,
        ERR_BAD_OP    = 3'd1,
        ERR_BAD_TABLE = 3'd2,
        ERR_BAD_POS   = 3'd3,
        ERR_FULL      = 3'd4
    } err_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHECK,
        ST_WALK,
        ST_EXEC,
        ST_RESP
    } state_t;

endpackage

// File: rtl/link_node_mem.sv
// Node pool: per-node successor pointer and payload, asynchronous reads,
// two successor write ports and one payload write port, no reset.
module link_node_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] ra_a,
    input  logic [ADDR_WIDTH-1:0] ra_b,
    output logic [ADDR_WIDTH-1:0] next_a,
    output logic [ADDR_WIDTH-1:0] next_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic                  nw1_en,
    input  logic [ADDR_WIDTH-1:0] nw1_addr,
    input  logic [ADDR_WIDTH-1:0] nw1_data,
    input  logic                  nw2_en,
    input  logic [ADDR_WIDTH-1:0] nw2_addr,
    input  logic [ADDR_WIDTH-1:0] nw2_data,
    input  logic                  dw_en,
    input  logic [ADDR_WIDTH-1:0] dw_addr,
    input  logic [DATA_WIDTH-1:0] dw_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] next_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    assign next_a = next_mem[ra_a];
    assign next_b = next_mem[ra_b];
    assign data_a = data_mem[ra_a];
    assign data_b = data_mem[ra_b];

    // Port 1 is written last so it takes precedence on an address clash.
    always_ff @(posedge clk) begin
        if (nw2_en) next_mem[nw2_addr] <= nw2_data;
        if (nw1_en) next_mem[nw1_addr] <= nw1_data;
        if (dw_en)  data_mem[dw_addr]  <= dw_data;
    end

endmodule

// File: rtl/link_table_mgr.sv
// Multi-table singly-linked-list engine: one order at a time, walks one hop
// per cycle, returns one response beat (data + error code) per order.
module link_table_mgr
    import link_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int TABLE_WIDTH = 3,
    parameter int NUM_TABLES  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   order_valid,
    output logic                   order_busy,
    input  logic [2:0]             order_type,
    input  logic [TABLE_WIDTH-1:0] order_table,
    input  logic [ADDR_WIDTH-1:0]  order_node,
    input  logic [DATA_WIDTH-1:0]  order_data,
    output logic                   dout_valid,
    input  logic                   dout_busy,
    output logic [DATA_WIDTH-1:0]  dout_data,
    output logic [2:0]             dout_err
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0]          FULL_CNT = LW'(1 << ADDR_WIDTH);
    localparam logic [TABLE_WIDTH:0]   NT       = (TABLE_WIDTH + 1)'(NUM_TABLES);

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]  init_cnt;
    logic [2:0]             typ_q;
    logic [TABLE_WIDTH-1:0] tbl_q;
    logic [ADDR_WIDTH-1:0]  pos_q;
    logic [DATA_WIDTH-1:0]  dat_q;
    logic [ADDR_WIDTH-1:0]  head_q [NUM_TABLES];
    logic [LW-1:0]          len_q  [NUM_TABLES];
    logic [ADDR_WIDTH-1:0]  free_head;
    logic [LW-1:0]          free_cnt;
    logic [ADDR_WIDTH-1:0]  cur_q;
    logic [ADDR_WIDTH-1:0]  hop_cnt;
    logic                   k_zero_q;

    logic                   tbl_ok, pos_bad;
    logic [LW-1:0]          tbl_len;
    logic [ADDR_WIDTH-1:0]  head_t, k, hops, v;
    err_t                   chk_err;

    logic [ADDR_WIDTH-1:0]  ra_a, ra_b, next_a, next_b;
    logic [DATA_WIDTH-1:0]  data_a, data_b;
    logic                   nw1_en, nw2_en, dw_en;
    logic [ADDR_WIDTH-1:0]  nw1_addr, nw1_data, nw2_addr, nw2_data, dw_addr;
    logic [DATA_WIDTH-1:0]  dw_data;

    // Order validation and hop count for the latched order.
    always_comb begin
        tbl_ok  = {1'b0, tbl_q} < NT;
        tbl_len = tbl_ok ? len_q[tbl_q] : '0;
        head_t  = tbl_ok ? head_q[tbl_q] : '0;
        k       = '0;
        pos_bad = 1'b0;
        case (typ_q)
            OP_APPE: begin
                k       = pos_q - 1'b1;
                pos_bad = (pos_q == '0) || ({1'b0, pos_q} > tbl_len + 1'b1);
            end
            OP_DELE: begin
                k       = pos_q - 1'b1;
                pos_bad = (pos_q == '0) || ({1'b0, pos_q} > tbl_len);
            end
            OP_CHAG, OP_READ: begin
                k       = pos_q;
                pos_bad = (pos_q == '0) || ({1'b0, pos_q} > tbl_len);
            end
            default: ;
        endcase
        hops = (k == '0) ? '0 : k - 1'b1;
        if (typ_q > 3'd4)                            chk_err = ERR_BAD_OP;
        else if (!tbl_ok)                            chk_err = ERR_BAD_TABLE;
        else if (pos_bad)                            chk_err = ERR_BAD_POS;
        else if (typ_q == OP_APPE && free_cnt == '0) chk_err = ERR_FULL;
        else                                         chk_err = ERR_OK;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_cnt == '1) state_d = ST_IDLE;
            ST_IDLE:  if (order_valid) state_d = ST_CHECK;
            ST_CHECK: begin
                if (chk_err != ERR_OK) state_d = ST_RESP;
                else if (hops != '0)   state_d = ST_WALK;
                else                   state_d = ST_EXEC;
            end
            ST_WALK:  if (hop_cnt == ADDR_WIDTH'(1)) state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_RESP;
            ST_RESP:  if (!dout_busy) state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            order_busy <= 1'b1;
            dout_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            order_busy <= (state_d != ST_IDLE);
            dout_valid <= (state_d == ST_RESP);
        end
    end

    // Node-pool port steering; v is the node being unlinked by DELE.
    always_comb begin
        v        = k_zero_q ? head_t : next_a;
        ra_a     = cur_q;
        ra_b     = free_head;
        nw1_en   = 1'b0;
        nw1_addr = '0;
        nw1_data = '0;
        nw2_en   = 1'b0;
        nw2_addr = '0;
        nw2_data = '0;
        dw_en    = 1'b0;
        dw_addr  = '0;
        dw_data  = '0;
        if (state_q == ST_INIT) begin
            nw1_en   = 1'b1;
            nw1_addr = init_cnt;
            nw1_data = init_cnt + 1'b1;
        end else if (state_q == ST_EXEC) begin
            case (typ_q)
                OP_APPE: begin
                    dw_en    = 1'b1;
                    dw_addr  = free_head;
                    dw_data  = dat_q;
                    nw1_en   = 1'b1;
                    nw1_addr = free_head;
                    nw1_data = k_zero_q ? head_t : next_a;
                    nw2_en   = !k_zero_q;
                    nw2_addr = cur_q;
                    nw2_data = free_head;
                end
                OP_DELE: begin
                    ra_b     = v;
                    nw1_en   = 1'b1;
                    nw1_addr = v;
                    nw1_data = free_head;
                    nw2_en   = !k_zero_q;
                    nw2_addr = cur_q;
                    nw2_data = next_b;
                end
                OP_CHAG: begin
                    dw_en   = 1'b1;
                    dw_addr = cur_q;
                    dw_data = dat_q;
                end
                default: ;
            endcase
        end
    end

    link_node_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk(clk),
        .ra_a(ra_a),       .ra_b(ra_b),
        .next_a(next_a),   .next_b(next_b),
        .data_a(data_a),   .data_b(data_b),
        .nw1_en(nw1_en),   .nw1_addr(nw1_addr), .nw1_data(nw1_data),
        .nw2_en(nw2_en),   .nw2_addr(nw2_addr), .nw2_data(nw2_data),
        .dw_en(dw_en),     .dw_addr(dw_addr),   .dw_data(dw_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt  <= '0;
            typ_q     <= '0;
            tbl_q     <= '0;
            pos_q     <= '0;
            dat_q     <= '0;
            free_head <= '0;
            free_cnt  <= FULL_CNT;
            cur_q     <= '0;
            hop_cnt   <= '0;
            k_zero_q  <= 1'b0;
            dout_data <= '0;
            dout_err  <= ERR_OK;
            for (int unsigned i = 0; i < NUM_TABLES; i++) begin
                head_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                ST_INIT: init_cnt <= init_cnt + 1'b1;
                ST_IDLE: if (order_valid) begin
                    typ_q <= order_type;
                    tbl_q <= order_table;
                    pos_q <= order_node;
                    dat_q <= order_data;
                end
                ST_CHECK: begin
                    cur_q    <= head_t;
                    hop_cnt  <= hops;
                    k_zero_q <= (k == '0);
                    if (chk_err != ERR_OK) begin
                        dout_data <= '0;
                        dout_err  <= chk_err;
                    end
                end
                ST_WALK: begin
                    cur_q   <= next_a;
                    hop_cnt <= hop_cnt - 1'b1;
                end
                ST_EXEC: begin
                    dout_err <= ERR_OK;
                    case (typ_q)
                        OP_APPE: begin
                            free_head <= next_b;
                            if (k_zero_q) head_q[tbl_q] <= free_head;
                            len_q[tbl_q] <= len_q[tbl_q] + 1'b1;
                            free_cnt     <= free_cnt - 1'b1;
                            dout_data    <= '0;
                        end
                        OP_DELE: begin
                            if (k_zero_q) head_q[tbl_q] <= next_b;
                            free_head    <= v;
                            len_q[tbl_q] <= len_q[tbl_q] - 1'b1;
                            free_cnt     <= free_cnt + 1'b1;
                            dout_data    <= data_b;
                        end
                        OP_CHAG, OP_READ: dout_data <= data_a;
                        default:          dout_data <= DATA_WIDTH'(tbl_len);
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_link_table_mgr.sv
// Directed bench for link_table_mgr: a default-size instance for list
// operations, errors, backpressure and reset, and an 8-node instance for FULL.
module tb_link_table_mgr;
    import link_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        order_valid = 1'b0, order_busy;
    logic [2:0]  order_type = '0, order_table = '0;
    logic [7:0]  order_node = '0;
    logic [15:0] order_data = '0;
    logic        dout_valid, dout_busy = 1'b0;
    logic [15:0] dout_data;
    logic [2:0]  dout_err;

    logic        s_order_valid = 1'b0, s_order_busy;
    logic [2:0]  s_order_type = '0, s_order_table = '0;
    logic [2:0]  s_order_node = '0;
    logic [15:0] s_order_data = '0;
    logic        s_dout_valid, s_dout_busy = 1'b0;
    logic [15:0] s_dout_data;
    logic [2:0]  s_dout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    link_table_mgr dut (
        .clk(clk), .rst_n(rst_n),
        .order_valid(order_valid), .order_busy(order_busy),
        .order_type(order_type), .order_table(order_table),
        .order_node(order_node), .order_data(order_data),
        .dout_valid(dout_valid), .dout_busy(dout_busy),
        .dout_data(dout_data), .dout_err(dout_err)
    );

    link_table_mgr #(.ADDR_WIDTH(3)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .order_valid(s_order_valid), .order_busy(s_order_busy),
        .order_type(s_order_type), .order_table(s_order_table),
        .order_node(s_order_node), .order_data(s_order_data),
        .dout_valid(s_dout_valid), .dout_busy(s_dout_busy),
        .dout_data(s_dout_data), .dout_err(s_dout_err)
    );

    task automatic issue(input logic [2:0] typ, input logic [2:0] tbl,
                         input logic [7:0] pos, input logic [15:0] d);
        int n = 0;
        while (order_busy !== 1'b0 && n < 1000) begin @(posedge clk); #1; n++; end
        total++;
        if (order_busy !== 1'b0) begin bad++; $display("FAIL issue_wait busy=%b want=0", order_busy); end
        order_valid = 1'b1; order_type = typ; order_table = tbl; order_node = pos; order_data = d;
        @(posedge clk); #1;
        order_valid = 1'b0; order_type = 3'd7; order_table = 3'd7; order_node = 8'hFF; order_data = 16'hDEAD;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (dout_valid !== 1'b1 && lat < 300) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic do_order(input logic [2:0] typ, input logic [2:0] tbl, input logic [7:0] pos,
                            input logic [15:0] d, output logic [15:0] rd, output logic [2:0] re,
                            output int lat);
        issue(typ, tbl, pos, d);
        wait_resp(lat);
        rd = dout_data; re = dout_err;
        dout_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_order_s(input logic [2:0] typ, input logic [2:0] tbl, input logic [2:0] pos,
                              input logic [15:0] d, output logic [15:0] rd, output logic [2:0] re);
        int n = 0;
        while (s_order_busy !== 1'b0 && n < 1000) begin @(posedge clk); #1; n++; end
        s_order_valid = 1'b1; s_order_type = typ; s_order_table = tbl; s_order_node = pos; s_order_data = d;
        @(posedge clk); #1;
        s_order_valid = 1'b0;
        n = 0;
        while (s_dout_valid !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        rd = (s_dout_valid === 1'b1) ? s_dout_data : 16'hBAD0;
        re = (s_dout_valid === 1'b1) ? s_dout_err : 3'd7;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        int n = 0;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (order_busy !== 1'b1 || dout_valid !== 1'b0 || dout_data !== 16'd0 || dout_err !== 3'd0) begin
            bad++; $display("FAIL reset_vals busy=%b valid=%b data=%0h err=%0d want 1 0 0 0",
                            order_busy, dout_valid, dout_data, dout_err);
        end
        total++;
        if (s_order_busy !== 1'b1 || s_dout_valid !== 1'b0) begin
            bad++; $display("FAIL reset_vals_s busy=%b valid=%b want 1 0", s_order_busy, s_dout_valid);
        end
        rst_n = 1'b1;
        while (order_busy !== 1'b0 && n < 1000) begin @(posedge clk); #1; n++; end
        total++;
        if (n < 256 || n > 257) begin bad++; $display("FAIL init_cycles got=%0d want=256..257", n); end
    endtask

    task automatic test_len_empty;
        logic [15:0] rd; logic [2:0] re; int lat;
        do_order(OP_LEN, 3'd0, 8'd0, 16'd0, rd, re, lat);
        total++;
        if (rd !== 16'd0 || re !== 3'd0 || lat !== 2) begin
            bad++; $display("FAIL len_empty data=%0d err=%0d lat=%0d want 0 0 2", rd, re, lat);
        end
    endtask

    task automatic test_append_read;
        logic [15:0] rd; logic [2:0] re; int lat;
        int exp_lat [3] = '{2, 2, 3};
        for (int i = 0; i < 3; i++) begin
            do_order(OP_APPE, 3'd3, 8'(i + 1), 16'(111 + i), rd, re, lat);
            total++;
            if (rd !== 16'd0 || re !== 3'd0 || lat !== exp_lat[i]) begin
                bad++; $display("FAIL append_%0d data=%0d err=%0d lat=%0d want 0 0 %0d", i + 1, rd, re, lat, exp_lat[i]);
            end
        end
        do_order(OP_READ, 3'd3, 8'd3, 16'd0, rd, re, lat);
        total++;
        if (rd !== 16'd113 || re !== 3'd0 || lat !== 4) begin
            bad++; $display("FAIL read_3_3 data=%0d err=%0d lat=%0d want 113 0 4", rd, re, lat);
        end
        do_order(OP_LEN, 3'd3, 8'd0, 16'd0, rd, re, lat);
        total++;
        if (rd !== 16'd3 || re !== 3'd0) begin bad++; $display("FAIL len_3 data=%0d err=%0d want 3 0", rd, re); end
    endtask

    task automatic test_insert_delete;
        logic [15:0] rd; logic [2:0] re; int lat;
        logic [15:0] exp_rd [4] = '{16'd111, 16'd50, 16'd112, 16'd113};
        do_order(OP_APPE, 3'd3, 8'd2, 16'd50, rd, re, lat);
        total++;
        if (re !== 3'd0) begin bad++; $display("FAIL insert_mid err=%0d want 0", re); end
        for (int i = 0; i < 4; i++) begin
            do_order(OP_READ, 3'd3, 8'(i + 1), 16'd0, rd, re, lat);
            total++;
            if (rd !== exp_rd[i] || re !== 3'd0) begin
                bad++; $display("FAIL read_pos%0d data=%0d err=%0d want %0d 0", i + 1, rd, re, exp_rd[i]);
            end
        end
        do_order(OP_DELE, 3'd3, 8'd1, 16'd0, rd, re, lat);
        total++;
        if (rd !== 16'd111 || re !== 3'd0) begin bad++; $display("FAIL delete_head data=%0d err=%0d want 111 0", rd, re); end
        do_order(OP_READ, 3'd3, 8'd1, 16'd0, rd, re, lat);
        total++;
        if (rd !== 16'd50) begin bad++; $display("FAIL read_new_head data=%0d want 50", rd); end
        do_order(OP_CHAG, 3'd3, 8'd1, 16'd2, rd, re, lat);
        total++;
        if (rd !== 16'd50 || re !== 3'd0) begin bad++; $display("FAIL change_old data=%0d err=%0d want 50 0", rd, re); end
        do_order(OP_READ, 3'd3, 8'd1, 16'd0, rd, re, lat);
        total++;
        if (rd !== 16'd2) begin bad++; $display("FAIL read_changed data=%0d want 2", rd); end
    endtask

    task automatic test_errors;
        logic [15:0] rd; logic [2:0] re; int lat;
        logic [2:0] typs [5] = '{3'd5, OP_READ, OP_APPE, OP_READ, OP_DELE};
        logic [2:0] tbls [5] = '{3'd3, 3'd6, 3'd1, 3'd3, 3'd3};
        logic [7:0] poss [5] = '{8'd1, 8'd1, 8'd3, 8'd0, 8'd4};
        logic [2:0] errs [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
        for (int i = 0; i < 5; i++) begin
            do_order(typs[i], tbls[i], poss[i], 16'd20, rd, re, lat);
            total++;
            if (rd !== 16'd0 || re !== errs[i] || lat !== 1) begin
                bad++; $display("FAIL err_case%0d data=%0d err=%0d lat=%0d want 0 %0d 1", i, rd, re, lat, errs[i]);
            end
        end
        do_order(OP_LEN, 3'd3, 8'd0, 16'd0, rd, re, lat);
        total++;
        if (rd !== 16'd3 || re !== 3'd0) begin bad++; $display("FAIL len_pos0 data=%0d err=%0d want 3 0", rd, re); end
        do_order(OP_APPE, 3'd3, 8'd4, 16'd114, rd, re, lat);
        total++;
        if (re !== 3'd0 || lat !== 4) begin bad++; $display("FAIL append_tail err=%0d lat=%0d want 0 4", re, lat); end
        do_order(OP_READ, 3'd3, 8'd4, 16'd0, rd, re, lat);
        total++;
        if (rd !== 16'd114 || lat !== 5) begin bad++; $display("FAIL read_tail data=%0d lat=%0d want 114 5", rd, lat); end
    endtask

    task automatic test_backpressure;
        int lat;
        dout_busy = 1'b1;
        issue(OP_READ, 3'd3, 8'd2, 16'd0);
        wait_resp(lat);
        total++;
        if (dout_data !== 16'd112 || dout_err !== 3'd0 || lat !== 3) begin
            bad++; $display("FAIL bp_first data=%0d err=%0d lat=%0d want 112 0 3", dout_data, dout_err, lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (dout_valid !== 1'b1 || dout_data !== 16'd112 || dout_err !== 3'd0 || order_busy !== 1'b1) begin
                bad++; $display("FAIL bp_hold%0d valid=%b data=%0d err=%0d busy=%b want 1 112 0 1",
                                i, dout_valid, dout_data, dout_err, order_busy);
            end
        end
        dout_busy = 1'b0;
        @(posedge clk); #1;
        total++;
        if (dout_valid !== 1'b0 || order_busy !== 1'b0) begin
            bad++; $display("FAIL bp_release valid=%b busy=%b want 0 0", dout_valid, order_busy);
        end
    endtask

    task automatic test_full_small;
        logic [15:0] rd; logic [2:0] re;
        logic [15:0] sum;
        for (int j = 1; j <= 4; j++) begin
            for (int t = 0; t < 2; t++) begin
                do_order_s(OP_APPE, 3'(t), 3'(j), 16'((t == 0 ? 16'hA0 : 16'hB0) + j), rd, re);
                total++;
                if (re !== 3'd0) begin bad++; $display("FAIL s_append_t%0d_p%0d err=%0d want 0", t, j, re); end
            end
        end
        do_order_s(OP_APPE, 3'd0, 3'd5, 16'hA5, rd, re);
        total++;
        if (re !== 3'd4 || rd !== 16'd0) begin bad++; $display("FAIL s_full err=%0d data=%0h want 4 0", re, rd); end
        do_order_s(OP_DELE, 3'd0, 3'd1, 16'd0, rd, re);
        total++;
        if (re !== 3'd0 || rd !== 16'hA1) begin bad++; $display("FAIL s_delete err=%0d data=%0h want 0 a1", re, rd); end
        do_order_s(OP_APPE, 3'd0, 3'd4, 16'hC4, rd, re);
        total++;
        if (re !== 3'd0) begin bad++; $display("FAIL s_reappend err=%0d want 0", re); end
        do_order_s(OP_READ, 3'd0, 3'd4, 16'd0, rd, re);
        total++;
        if (rd !== 16'hC4) begin bad++; $display("FAIL s_read_tail data=%0h want c4", rd); end
        do_order_s(OP_LEN, 3'd0, 3'd0, 16'd0, rd, re);
        sum = rd;
        do_order_s(OP_LEN, 3'd1, 3'd0, 16'd0, rd, re);
        sum = sum + rd;
        total++;
        if (sum !== 16'd8) begin bad++; $display("FAIL s_len_sum got=%0d want 8", sum); end
    endtask

    task automatic test_reset_walk;
        logic [15:0] rd; logic [2:0] re; int lat;
        int n = 0;
        issue(OP_READ, 3'd3, 8'd4, 16'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (dout_valid !== 1'b0 || order_busy !== 1'b1) begin
            bad++; $display("FAIL rst_walk valid=%b busy=%b want 0 1", dout_valid, order_busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        while (order_busy !== 1'b0 && n < 1000) begin
            @(posedge clk); #1; n++;
            if (dout_valid !== 1'b0) break;
        end
        total++;
        if (n < 256 || n > 257 || dout_valid !== 1'b0) begin
            bad++; $display("FAIL rst_reinit cycles=%0d valid=%b want 256..257 0", n, dout_valid);
        end
        for (int t = 0; t < 6; t++) begin
            do_order(OP_LEN, 3'(t), 8'd0, 16'd0, rd, re, lat);
            total++;
            if (rd !== 16'd0 || re !== 3'd0) begin bad++; $display("FAIL rst_len_t%0d data=%0d err=%0d want 0 0", t, rd, re); end
        end
        do_order_s(OP_LEN, 3'd0, 3'd0, 16'd0, rd, re);
        total++;
        if (rd !== 16'd0) begin bad++; $display("FAIL rst_len_small data=%0d want 0", rd); end
    endtask

    initial begin
        test_reset;
        test_len_empty;
        test_append_read;
        test_insert_delete;
        test_errors;
        test_backpressure;
        test_full_small;
        test_reset_walk;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/link_table_mgr.md
Name: link_table_mgr

Overview:
- Multi-table singly-linked-list engine with an on-chip node pool and a hardware free list.
- Accepts one order at a time (append/delete/change/read/length) addressed by table number and 1-based position.
- Walks the list one hop per cycle and returns exactly one response beat per order, including error status.
- Successor of the current link table core: adds a length query, free-list full detection, error reporting, and returned data for every op.

Parameters:
- ADDR_WIDTH, 8, node pointer width; NODE_DEPTH = 2**ADDR_WIDTH nodes; also the order_node width.
- DATA_WIDTH, 16, node payload width; must be >= ADDR_WIDTH+1.
- TABLE_WIDTH, 3, order_table width.
- NUM_TABLES, 6, number of implemented tables; must be <= 2**TABLE_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- order_valid  in  1  order request
- order_busy  out  1  engine cannot accept; order accepted on posedge with order_valid=1 and order_busy=0
- order_type  in  3  0 APPE, 1 DELE, 2 CHAG, 3 READ, 4 LEN, 5-7 illegal
- order_table  in  TABLE_WIDTH  table index
- order_node  in  ADDR_WIDTH  1-based position
- order_data  in  DATA_WIDTH  payload for APPE/CHAG
- dout_valid  out  1  response valid
- dout_busy  in  1  consumer stall; response consumed on posedge with dout_valid=1 and dout_busy=0
- dout_data  out  DATA_WIDTH  response data
- dout_err  out  3  0 OK, 1 BAD_OP, 2 BAD_TABLE, 3 BAD_POS, 4 FULL

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state INIT, order_busy=1, dout_valid=0, dout_data=0, dout_err=0.
- All per-table head pointers = 0; all per-table lengths (ADDR_WIDTH+1 bits) = 0; free_head=0; free_cnt=NODE_DEPTH.
- INIT: NODE_DEPTH cycles writing next[i]=i+1, then IDLE. Reset asserted in any state aborts the operation and restarts INIT, discarding all lists.
- order_busy is registered: 1 in every state except IDLE. dout_valid=1 only in RESP.
- IDLE: on accept, latch type/table/node/data, then go to CHECK.
- CHECK, one cycle; error priority BAD_OP > BAD_TABLE (table >= NUM_TABLES) > BAD_POS > FULL.
  - BAD_POS: APPE with pos 0 or pos > len+1; DELE/CHAG/READ with pos 0 or pos > len.
  - FULL: APPE with free_cnt==0.
  - LEN never raises BAD_POS.
  - On error: go to RESP, dout_data=0.
  - Otherwise: k = pos-1 for APPE/DELE, pos for CHAG/READ, 0 for LEN; cur=head[t]; hops h = max(k-1,0); go to WALK if h>0, else EXEC.
- WALK: cur<=next[cur] each cycle, for h cycles, then EXEC.
- EXEC, one cycle; all reads use pre-edge values:
  - APPE: n=free_head; data[n]=d; free_head=next[n]; if k==0 {next[n]=head[t]; head[t]=n} else {next[n]=next[cur]; next[cur]=n}; len++; free_cnt--; dout_data=0.
  - DELE: v = (k==0) ? head[t] : next[cur]; unlink v (update head[t] or next[cur] to next[v]); next[v]=free_head; free_head=v; len--; free_cnt++; dout_data=data[v].
  - CHAG: dout_data = old data[cur]; data[cur]=d.
  - READ: dout_data=data[cur].
  - LEN: dout_data = zero-extended len[t].
  - dout_err=OK in all cases above.
- Latency (A = accept edge): errors → dout_valid high after edge A+1; success → after edge A+2+h.
- RESP: dout_valid, dout_data and dout_err held stable while dout_busy=1. On the consuming edge go to IDLE; order_busy falls at that edge.
- Order fields change while busy: ignored (values are latched at accept).

Decomposition:
- Package link_pkg holds:
  - op enum (APPE/DELE/CHAG/READ/LEN);
  - err enum;
  - FSM state enum (INIT, IDLE, CHECK, WALK, EXEC, RESP).
- Sub-module link_node_mem: NODE_DEPTH × {next, data} register array, no reset.
  - Asynchronous reads.
  - Two next write ports (port 1 wins on same address; never occurs by construction).
  - One data write port.
  - Init write driven from INIT.

Test Plan:
- Reset, wait for order_busy=0 (≈NODE_DEPTH+1 cycles) → LEN(0) returns 0, err OK; order_busy=1 throughout INIT.
- append(3,1,111), (3,2,112), (3,3,113); read(3,3) → 113, dout_valid 4 edges after accept (h=2); LEN(3) → 3.
- append(3,2,50) → reads of positions 1..4 give 111, 50, 112, 113; delete(3,1) → dout_data 111; read(3,1) → 50; write(3,1,2) → dout_data 50; read(3,1) → 2.
- Errors:
  - type 5 → BAD_OP;
  - table 6 → BAD_TABLE;
  - append(1,3,20) on empty table 1 → BAD_POS;
  - read(3,0) → BAD_POS;
  - all error responses one edge after accept with dout_data=0.
- ADDR_WIDTH=3: 8 appends across tables 0/1 OK, 9th → FULL; delete(0,1) then append OK; final LEN sum = 8.
- Backpressure and reset:
  - dout_busy=1 for 5 cycles in RESP → outputs stable, order_busy=1.
  - rst_n low mid-WALK → immediately dout_valid=0, order_busy=1; INIT reruns; LEN of all tables = 0.
